redmule_mx_decoder_mlane: RTL

Multi-lane MX-to-FP16 decoder and successor to the single-lane redmule_mx_decoder. It unpacks wide MX beats of FP8 elements (E4M3 or E5M2, chosen per beat). Each element is scaled by a shared E8M0 exponent that applies to every BLOCK_SIZE elements, and the results leave as NUM_LANES FP16 values per cycle. It sits between the streamer's MX load path and the RedMulE datapath, and it buffers one beat and one exponent under full valid/ready backpressure.

---
 rtl/redmule_mx_decoder_mlane.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/redmule_mx_decoder_mlane.sv
// Multi-lane MX (FP8 E4M3/E5M2 + shared E8M0 scale) to FP16 decoder, NUM_LANES results per transfer.
// Optional REDMULE_MX_SAT_EN: overflow/infinity saturate to +-0x7BFF and sat_flag_o is added.
module redmule_mx_decoder_mlane #(
  parameter int DATA_W     = 256,
  parameter int ELEM_W     = 8,
  parameter int NUM_LANES  = 4,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fmt_i,
  input  logic                    mx_val_valid_i,
  output logic                    mx_val_ready_o,
  input  logic [DATA_W-1:0]       mx_val_data_i,
  input  logic                    mx_exp_valid_i,
  output logic                    mx_exp_ready_o,
  input  logic [7:0]              mx_exp_data_i,
  output logic                    fp16_valid_o,
  input  logic                    fp16_ready_i,
  output logic [NUM_LANES*16-1:0] fp16_data_o,
  output logic                    busy_o
`ifdef REDMULE_MX_SAT_EN
  ,output logic                   sat_flag_o
`endif
);

  localparam int EPB       = DATA_W / ELEM_W;
  localparam int CHUNKS    = EPB / NUM_LANES;
  localparam int BPB       = BLOCK_SIZE / EPB;
  localparam int CH_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int BT_W      = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int LANE_BITS = NUM_LANES * ELEM_W;

  if (ELEM_W != 8) begin : g_elem_w_chk
    $error("redmule_mx_decoder_mlane: ELEM_W must be 8");
  end
  if ((EPB % NUM_LANES) != 0) begin : g_lanes_chk
    $error("redmule_mx_decoder_mlane: DATA_W/ELEM_W must be a multiple of NUM_LANES");
  end
  if ((BLOCK_SIZE % EPB) != 0) begin : g_block_chk
    $error("redmule_mx_decoder_mlane: BLOCK_SIZE must be a multiple of DATA_W/ELEM_W");
  end

  function automatic logic [15:0] ovf_val(input logic s);
`ifdef REDMULE_MX_SAT_EN
    return {s, 15'h7BFF};
`else
    return {s, 15'h7C00};
`endif
  endfunction

  function automatic logic [15:0] cvt_elem(input logic [7:0] el, input logic fmt, input logic [7:0] x);
    logic              s;
    logic signed [10:0] e_eff;
    logic signed [10:0] e_fp;
    logic [9:0]        mant;
    s     = el[7];
    e_eff = '0;
    e_fp  = '0;
    mant  = '0;
    if (x == 8'hFF) return 16'h7E00;
    if (!fmt) begin
      if (el[6:0] == 7'h7F) return 16'h7E00;
      if (el[6:0] == 7'h00) return {s, 15'h0};
      // subnormals: shift the leading one out and lower the exponent to match
      if (el[6:3] != 4'd0) begin e_eff = $signed({7'd0, el[6:3]}); mant = {el[2:0], 7'd0}; end
      else if (el[2])      begin e_eff = 11'sd0;  mant = {el[1:0], 8'd0}; end
      else if (el[1])      begin e_eff = -11'sd1; mant = {el[0], 9'd0}; end
      else                 begin e_eff = -11'sd2; mant = 10'd0; end
      e_fp = e_eff + $signed({3'd0, x}) - 11'sd119;
    end else begin
      if (el[6:2] == 5'h1F) return (el[1:0] != 2'b00) ? 16'h7E00 : ovf_val(s);
      if (el[6:0] == 7'h00) return {s, 15'h0};
      if (el[6:2] != 5'd0) begin e_eff = $signed({6'd0, el[6:2]}); mant = {el[1:0], 8'd0}; end
      else if (el[1])      begin e_eff = 11'sd0;  mant = {el[0], 9'd0}; end
      else                 begin e_eff = -11'sd1; mant = 10'd0; end
      e_fp = e_eff + $signed({3'd0, x}) - 11'sd127;
    end
    if (e_fp >= 11'sd31) return ovf_val(s);
    if (e_fp <= 11'sd0)  return {s, 15'h0};
    return {s, e_fp[4:0], mant};
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT_VAL, DRAIN} state_e;
  state_e state, nxt_state;

  logic [DATA_W-1:0]      beat_q;
  logic                   fmt_q;
  logic [7:0]             exp_q;
  logic [CH_W-1:0]        chunk_q, sel_chunk;
  logic [BT_W-1:0]        beat_cnt;
  logic                   exp_rdy, val_rdy, acc_exp, acc_val;
  logic                   adv_chunk, clr_vld, beat_inc, beat_clr;
  logic                   out_fire, last_chunk;
  logic [DATA_W-1:0]      src_data;
  logic                   src_fmt;
  logic [7:0]             src_exp;
  logic [LANE_BITS-1:0]   chunk_arr [CHUNKS];
  logic [LANE_BITS-1:0]   cur_chunk;
  logic [NUM_LANES*16-1:0] conv;

  assign out_fire   = fp16_valid_o & fp16_ready_i;
  assign last_chunk = (chunk_q == CH_W'(CHUNKS - 1));

  always_comb begin
    nxt_state = state;
    exp_rdy   = 1'b0;
    val_rdy   = 1'b0;
    adv_chunk = 1'b0;
    clr_vld   = 1'b0;
    beat_inc  = 1'b0;
    beat_clr  = 1'b0;
    case (state)
      IDLE: begin
        exp_rdy = 1'b1;
        if (mx_exp_valid_i) nxt_state = WAIT_VAL;
      end
      WAIT_VAL: begin
        val_rdy = 1'b1;
        if (mx_val_valid_i) nxt_state = DRAIN;
      end
      DRAIN: begin
        if (out_fire) begin
          if (!last_chunk) begin
            adv_chunk = 1'b1;
          end else if (beat_cnt != BT_W'(BPB - 1)) begin
            beat_inc = 1'b1;
            val_rdy  = 1'b1;
            if (!mx_val_valid_i) begin clr_vld = 1'b1; nxt_state = WAIT_VAL; end
          end else begin
            // a beat of the next block may only ride along with its own exponent
            beat_clr = 1'b1;
            exp_rdy  = 1'b1;
            val_rdy  = mx_exp_valid_i;
            if (!mx_exp_valid_i)      begin clr_vld = 1'b1; nxt_state = IDLE; end
            else if (!mx_val_valid_i) begin clr_vld = 1'b1; nxt_state = WAIT_VAL; end
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign mx_exp_ready_o = exp_rdy & rst_ni;
  assign mx_val_ready_o = val_rdy & rst_ni;
  assign acc_exp        = mx_exp_ready_o & mx_exp_valid_i;
  assign acc_val        = mx_val_ready_o & mx_val_valid_i;
  assign busy_o         = (state != IDLE);

  // convert straight from the input port on acceptance so the first chunk costs no extra cycle
  assign src_data  = acc_val ? mx_val_data_i : beat_q;
  assign src_fmt   = acc_val ? fmt_i : fmt_q;
  assign src_exp   = acc_exp ? mx_exp_data_i : exp_q;
  assign sel_chunk = acc_val ? '0 : chunk_q + CH_W'(1);

  for (genvar c = 0; c < CHUNKS; c++) begin : g_chunk
    assign chunk_arr[c] = src_data[c*LANE_BITS +: LANE_BITS];
  end
  assign cur_chunk = chunk_arr[sel_chunk];

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign conv[j*16 +: 16] = cvt_elem(cur_chunk[j*ELEM_W +: 8], src_fmt, src_exp);
  end

`ifdef REDMULE_MX_SAT_EN
  // 0x7BFF is unreachable by exact conversion (FP8 mantissas leave the low bits clear)
  logic [NUM_LANES-1:0] lane_sat;
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_sat
    assign lane_sat[j] = (conv[j*16 +: 15] == 15'h7BFF);
  end
`endif

  // Output stage: registered chunk, valid and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      chunk_q      <= '0;
      beat_cnt     <= '0;
      fp16_valid_o <= 1'b0;
      fp16_data_o  <= '0;
`ifdef REDMULE_MX_SAT_EN
      sat_flag_o   <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      if (acc_val || adv_chunk) begin
        fp16_valid_o <= 1'b1;
        fp16_data_o  <= conv;
        chunk_q      <= sel_chunk;
`ifdef REDMULE_MX_SAT_EN
        sat_flag_o   <= |lane_sat;
`endif
      end else if (clr_vld) begin
        fp16_valid_o <= 1'b0;
      end
      if (beat_inc)      beat_cnt <= beat_cnt + BT_W'(1);
      else if (beat_clr) beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_exp) exp_q <= mx_exp_data_i;
    if (acc_val) begin
      beat_q <= mx_val_data_i;
      fmt_q  <= fmt_i;
    end
  end

endmodule
